// File: rtl/sa_20.sv
// Switch allocator and crossbar for mesh node (2,0): per-output round-robin
// arbitration with wormhole locking over the N, E and L ports.
module sa_20 #(
    parameter int unsigned DATASIZE = 40
) (
    input  logic                sa_clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] data_in_1,
    input  logic [DATASIZE-1:0] data_in_2,
    input  logic [DATASIZE-1:0] data_in_5,
    input  logic [3:0]          direction_in_1,
    input  logic [3:0]          direction_in_2,
    input  logic [3:0]          direction_in_5,
    output logic                sa_ready_1,
    output logic                sa_ready_2,
    output logic                sa_ready_5,
    output logic [DATASIZE-1:0] data_out_1,
    output logic [DATASIZE-1:0] data_out_2,
    output logic [DATASIZE-1:0] data_out_5,
    output logic                valid_out_1,
    output logic                valid_out_2,
    output logic                valid_out_5,
    input  logic                ready_in_1,
    input  logic                ready_in_2,
    input  logic                ready_in_5,
    output logic                err_out
);

    localparam int unsigned NP = 3;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    logic [DATASIZE-1:0] din    [NP];
    logic [3:0]          dir    [NP];
    logic [DATASIZE-1:0] dout_q [NP];
    logic [NP-1:0]       rdy_in;
    logic [NP-1:0]       vld_q;

    state_t              st_q   [NP];
    state_t              st_d   [NP];
    logic [1:0]          own_q  [NP];
    logic [1:0]          own_d  [NP];
    logic [1:0]          ptr_q  [NP];
    logic [1:0]          ptr_d  [NP];

    logic [NP-1:0]       req_ok;
    logic [NP-1:0]       drop;
    logic [NP-1:0]       is_hs;
    logic [NP-1:0]       is_tail;
    logic [1:0]          tgt    [NP];
    logic [NP-1:0]       elig   [NP];
    logic [2:0]          pick   [NP];
    logic [1:0]          win    [NP];
    logic [NP-1:0]       grant;
    logic [NP-1:0]       ack;
    logic                err_d;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Returns {found, index} of the first eligible input at or after ptr.
    function automatic logic [2:0] rr_pick(input logic [2:0] el, input logic [1:0] ptr);
        logic [1:0] c;
        logic [2:0] r;
        r = 3'b000;
        c = ptr;
        for (int k = 0; k < 3; k++) begin
            if (!r[2] && el[c]) r = {1'b1, c};
            c = inc3(c);
        end
        return r;
    endfunction

    assign din[0] = data_in_1;
    assign din[1] = data_in_2;
    assign din[2] = data_in_5;
    assign dir[0] = direction_in_1;
    assign dir[1] = direction_in_2;
    assign dir[2] = direction_in_5;
    assign rdy_in = {ready_in_5, ready_in_2, ready_in_1};

    // Direction decode: legal targets, illegal codes and U-turns.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            tgt[i]     = 2'd0;
            req_ok[i]  = 1'b0;
            drop[i]    = 1'b0;
            is_hs[i]   = din[i][DATASIZE-1];
            is_tail[i] = (din[i][DATASIZE-1 -: 2] == 2'b01);
            case (dir[i])
                4'd0: ;
                4'd1: begin tgt[i] = 2'd0; req_ok[i] = 1'b1; end
                4'd2: begin tgt[i] = 2'd1; req_ok[i] = 1'b1; end
                4'd5: begin tgt[i] = 2'd2; req_ok[i] = 1'b1; end
                default: drop[i] = 1'b1;
            endcase
            if (req_ok[i] && tgt[i] == 2'(i)) begin
                req_ok[i] = 1'b0;
                drop[i]   = 1'b1;
            end
        end
    end

    // Per-output arbitration and lock state next-state logic.
    always_comb begin
        ack   = drop;
        err_d = |drop;
        grant = '0;
        for (int p = 0; p < NP; p++) begin
            st_d[p]  = st_q[p];
            own_d[p] = own_q[p];
            ptr_d[p] = ptr_q[p];
            win[p]   = 2'd0;
            elig[p]  = '0;
            for (int i = 0; i < NP; i++) begin
                if (req_ok[i] && tgt[i] == 2'(p)) begin
                    if (st_q[p] == ST_IDLE) begin
                        elig[p][i] = is_hs[i];
                    end else if (own_q[p] == 2'(i)) begin
                        if (is_hs[i]) begin
                            ack[i] = 1'b1;
                            err_d  = 1'b1;
                        end else begin
                            elig[p][i] = 1'b1;
                        end
                    end
                end
            end
            pick[p] = rr_pick(elig[p], ptr_q[p]);
            if (pick[p][2] && (!vld_q[p] || rdy_in[p])) begin
                grant[p]    = 1'b1;
                win[p]      = pick[p][1:0];
                ack[win[p]] = 1'b1;
                if (st_q[p] == ST_IDLE) begin
                    ptr_d[p] = inc3(win[p]);
                    if (!din[win[p]][DATASIZE-2]) begin
                        st_d[p]  = ST_LOCKED;
                        own_d[p] = win[p];
                    end
                end else if (is_tail[win[p]]) begin
                    st_d[p] = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge sa_clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                vld_q[p]  <= 1'b0;
                dout_q[p] <= '0;
                st_q[p]   <= ST_IDLE;
                own_q[p]  <= 2'd0;
                ptr_q[p]  <= 2'd0;
            end
            err_out <= 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                st_q[p]  <= st_d[p];
                own_q[p] <= own_d[p];
                ptr_q[p] <= ptr_d[p];
                if (grant[p]) begin
                    dout_q[p] <= din[win[p]];
                    vld_q[p]  <= 1'b1;
                end else if (rdy_in[p]) begin
                    vld_q[p]  <= 1'b0;
                end
            end
            err_out <= err_d;
        end
    end

    assign sa_ready_1  = ack[0] & ~rst;
    assign sa_ready_2  = ack[1] & ~rst;
    assign sa_ready_5  = ack[2] & ~rst;
    assign data_out_1  = dout_q[0];
    assign data_out_2  = dout_q[1];
    assign data_out_5  = dout_q[2];
    assign valid_out_1 = vld_q[0];
    assign valid_out_2 = vld_q[1];
    assign valid_out_5 = vld_q[2];

endmodule
